// File: rtl/wdata_burst_drain_if.sv
// Handshake bundle between the write-data queue head, the scheduler, and the DQ beat output.
interface wdata_burst_drain_if #(
    parameter int WIDTH  = 1024,
    parameter int BEAT_W = 128,
    parameter int LAT_W  = 4
);
    logic              q_valid;
    logic [WIDTH-1:0]  q_data;
    logic              q_pop;
    logic              wr_go;
    logic [LAT_W-1:0]  wr_lat;
    logic [BEAT_W-1:0] dq_out;
    logic              dq_valid;
    logic              dq_last;
    logic              busy;
    logic              err_underrun;
    logic              err_busy;

    modport master (
        output q_valid, q_data, wr_go, wr_lat,
        input  q_pop, dq_out, dq_valid, dq_last, busy, err_underrun, err_busy
    );

    modport slave (
        input  q_valid, q_data, wr_go, wr_lat,
        output q_pop, dq_out, dq_valid, dq_last, busy, err_underrun, err_busy
    );
endinterface

// File: rtl/wdata_burst_drain.sv
// Pops one queue entry per accepted write command and serializes it LSB-first as BURST beats
// onto the DQ bus after a programmable write latency.
module wdata_burst_drain #(
    parameter int WIDTH  = 1024,
    parameter int BEAT_W = 128,
    parameter int LAT_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    wdata_burst_drain_if.slave    bus
);
    localparam int BURST = WIDTH / BEAT_W;
    localparam int BC_W  = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(BURST - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_LAT = 2'd1,
        S_BURST    = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [LAT_W-1:0]  lat_cnt;
    logic [BC_W-1:0]   beat_cnt;
    logic [WIDTH-1:0]  sreg;
    logic              last_beat;
    logic              in_window;
    logic              accept;
    logic              underrun;
    logic              collide;
    logic              err_underrun_q;
    logic              err_busy_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // accept is gated by rst so no pop can escape while the block is held in reset
    always_comb begin
        state_nxt    = state;
        last_beat    = (state == S_BURST) && (beat_cnt == LAST_BEAT);
        in_window    = (state == S_IDLE) || last_beat;
        accept       = rst && in_window && bus.wr_go && bus.q_valid;
        underrun     = in_window && bus.wr_go && !bus.q_valid;
        collide      = bus.wr_go && !in_window;

        case (state)
            S_IDLE: begin
                if (accept)
                    state_nxt = (bus.wr_lat == '0) ? S_BURST : S_WAIT_LAT;
            end
            S_WAIT_LAT: begin
                if (lat_cnt <= LAT_W'(1))
                    state_nxt = S_BURST;
            end
            S_BURST: begin
                if (last_beat) begin
                    if (accept)
                        state_nxt = (bus.wr_lat == '0) ? S_BURST : S_WAIT_LAT;
                    else
                        state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        bus.q_pop    = accept;
        bus.busy     = (state != S_IDLE);
        bus.dq_valid = (state == S_BURST);
        bus.dq_last  = last_beat;
        bus.dq_out   = (state == S_BURST) ? sreg[BEAT_W-1:0] : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_cnt        <= '0;
            beat_cnt       <= '0;
            err_underrun_q <= 1'b0;
            err_busy_q     <= 1'b0;
        end else begin
            err_underrun_q <= underrun;
            err_busy_q     <= collide;

            if (accept)
                lat_cnt <= bus.wr_lat;
            else if ((state == S_WAIT_LAT) && (lat_cnt != '0))
                lat_cnt <= lat_cnt - LAT_W'(1);

            if ((state == S_BURST) && !last_beat)
                beat_cnt <= beat_cnt + BC_W'(1);
            else
                beat_cnt <= '0;
        end
    end

    // Data path carries no reset: contents are only observable while in S_BURST
    always_ff @(posedge clk) begin
        if (accept)
            sreg <= bus.q_data;
        else if (state == S_BURST)
            sreg <= sreg >> BEAT_W;
    end

    assign bus.err_underrun = err_underrun_q;
    assign bus.err_busy     = err_busy_q;

endmodule

// File: tb/tb_wdata_burst_drain.sv
// Directed bench for wdata_burst_drain: reset, latency, gapless back-to-back, underrun, busy collision,
// and mid-burst reset.
module tb_wdata_burst_drain;
    localparam int WIDTH  = 1024;
    localparam int BEAT_W = 128;
    localparam int LAT_W  = 4;
    localparam int BURST  = WIDTH / BEAT_W;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    wdata_burst_drain_if #(.WIDTH(WIDTH), .BEAT_W(BEAT_W), .LAT_W(LAT_W)) bus_if ();

    wdata_burst_drain #(.WIDTH(WIDTH), .BEAT_W(BEAT_W), .LAT_W(LAT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Entry whose beat k holds base+k
    function automatic logic [WIDTH-1:0] mk(input logic [7:0] base);
        logic [WIDTH-1:0] d;
        d = '0;
        for (int k = 0; k < BURST; k++)
            d[k*BEAT_W +: BEAT_W] = BEAT_W'(base) + BEAT_W'(k);
        return d;
    endfunction

    // flags = {q_pop, dq_valid, dq_last, busy, err_underrun, err_busy}
    task automatic test_reset();
        logic [5:0] obs;
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            bus_if.q_valid = 1'($urandom);
            bus_if.wr_go   = 1'($urandom);
            bus_if.wr_lat  = LAT_W'($urandom);
            for (int w = 0; w < WIDTH/32; w++) bus_if.q_data[w*32 +: 32] = $urandom;
            @(negedge clk);
            obs = {bus_if.q_pop, bus_if.dq_valid, bus_if.dq_last, bus_if.busy,
                   bus_if.err_underrun, bus_if.err_busy};
            checks++;
            if (obs !== 6'b0) begin
                errors++;
                $display("FAIL reset_flags cyc %0d got %b exp %b", c, obs, 6'b0);
            end
            checks++;
            if (bus_if.dq_out !== '0) begin
                errors++;
                $display("FAIL reset_dq_out cyc %0d got %h exp 0", c, bus_if.dq_out);
            end
        end
        @(posedge clk); #1;
        bus_if.q_valid = 1'b0;
        bus_if.wr_go   = 1'b0;
        bus_if.wr_lat  = '0;
        bus_if.q_data  = '0;
        rst = 1'b1;
        @(negedge clk);
        obs = {bus_if.q_pop, bus_if.dq_valid, bus_if.dq_last, bus_if.busy,
               bus_if.err_underrun, bus_if.err_busy};
        checks++;
        if (obs !== 6'b0) begin
            errors++;
            $display("FAIL post_reset_idle got %b exp %b", obs, 6'b0);
        end
    endtask

    task automatic test_single_lat3();
        logic [5:0]        obs;
        logic [5:0]        exp_f;
        logic [BEAT_W-1:0] exp_d;
        bus_if.q_valid = 1'b1;
        bus_if.q_data  = mk(8'h00);
        bus_if.wr_lat  = LAT_W'(3);
        for (int c = 0; c <= 24; c++) begin
            @(posedge clk); #1;
            bus_if.wr_go = (c == 10);
            @(negedge clk);
            exp_f = {c == 10, (c >= 14 && c <= 21), c == 21, (c >= 11 && c <= 21), 1'b0, 1'b0};
            exp_d = (c >= 14 && c <= 21) ? BEAT_W'(c - 14) : '0;
            obs = {bus_if.q_pop, bus_if.dq_valid, bus_if.dq_last, bus_if.busy,
                   bus_if.err_underrun, bus_if.err_busy};
            checks++;
            if (obs !== exp_f) begin
                errors++;
                $display("FAIL lat3_flags cyc %0d got %b exp %b", c, obs, exp_f);
            end
            checks++;
            if (bus_if.dq_out !== exp_d) begin
                errors++;
                $display("FAIL lat3_dq_out cyc %0d got %h exp %h", c, bus_if.dq_out, exp_d);
            end
        end
        bus_if.wr_go   = 1'b0;
        bus_if.q_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [5:0]        obs;
        logic [5:0]        exp_f;
        logic [BEAT_W-1:0] exp_d;
        int                pops;
        pops = 0;
        bus_if.wr_lat = '0;
        for (int c = 0; c <= 24; c++) begin
            @(posedge clk); #1;
            bus_if.q_valid = (c <= 13);
            bus_if.q_data  = (c <= 5) ? mk(8'hA0) : mk(8'hB0);
            bus_if.wr_go   = (c == 5) || (c == 13);
            @(negedge clk);
            if (bus_if.q_pop === 1'b1) pops++;
            exp_f = {(c == 5) || (c == 13), (c >= 6 && c <= 21), (c == 13) || (c == 21),
                     (c >= 6 && c <= 21), 1'b0, 1'b0};
            if (c >= 6 && c <= 13)       exp_d = BEAT_W'(8'hA0 + (c - 6));
            else if (c >= 14 && c <= 21) exp_d = BEAT_W'(8'hB0 + (c - 14));
            else                         exp_d = '0;
            obs = {bus_if.q_pop, bus_if.dq_valid, bus_if.dq_last, bus_if.busy,
                   bus_if.err_underrun, bus_if.err_busy};
            checks++;
            if (obs !== exp_f) begin
                errors++;
                $display("FAIL b2b_flags cyc %0d got %b exp %b", c, obs, exp_f);
            end
            checks++;
            if (bus_if.dq_out !== exp_d) begin
                errors++;
                $display("FAIL b2b_dq_out cyc %0d got %h exp %h", c, bus_if.dq_out, exp_d);
            end
        end
        checks++;
        if (pops !== 2) begin
            errors++;
            $display("FAIL b2b_pop_count got %0d exp 2", pops);
        end
        bus_if.wr_go   = 1'b0;
        bus_if.q_valid = 1'b0;
    endtask

    task automatic test_underrun();
        logic [5:0] obs;
        logic [5:0] exp_f;
        bus_if.q_valid = 1'b0;
        bus_if.q_data  = mk(8'h11);
        bus_if.wr_lat  = LAT_W'(2);
        for (int c = 0; c <= 10; c++) begin
            @(posedge clk); #1;
            bus_if.wr_go = (c == 5);
            @(negedge clk);
            exp_f = {1'b0, 1'b0, 1'b0, 1'b0, c == 6, 1'b0};
            obs = {bus_if.q_pop, bus_if.dq_valid, bus_if.dq_last, bus_if.busy,
                   bus_if.err_underrun, bus_if.err_busy};
            checks++;
            if (obs !== exp_f) begin
                errors++;
                $display("FAIL underrun_flags cyc %0d got %b exp %b", c, obs, exp_f);
            end
            checks++;
            if (bus_if.dq_out !== '0) begin
                errors++;
                $display("FAIL underrun_dq_out cyc %0d got %h exp 0", c, bus_if.dq_out);
            end
        end
        bus_if.wr_go = 1'b0;
    endtask

    task automatic test_busy_collision();
        logic [5:0]        obs;
        logic [5:0]        exp_f;
        logic [BEAT_W-1:0] exp_d;
        bus_if.q_valid = 1'b1;
        bus_if.q_data  = mk(8'hC0);
        bus_if.wr_lat  = LAT_W'(5);
        for (int c = 0; c <= 21; c++) begin
            @(posedge clk); #1;
            bus_if.wr_go = (c == 5) || (c == 7);
            @(negedge clk);
            exp_f = {c == 5, (c >= 11 && c <= 18), c == 18, (c >= 6 && c <= 18), 1'b0, c == 8};
            exp_d = (c >= 11 && c <= 18) ? BEAT_W'(8'hC0 + (c - 11)) : '0;
            obs = {bus_if.q_pop, bus_if.dq_valid, bus_if.dq_last, bus_if.busy,
                   bus_if.err_underrun, bus_if.err_busy};
            checks++;
            if (obs !== exp_f) begin
                errors++;
                $display("FAIL busy_flags cyc %0d got %b exp %b", c, obs, exp_f);
            end
            checks++;
            if (bus_if.dq_out !== exp_d) begin
                errors++;
                $display("FAIL busy_dq_out cyc %0d got %h exp %h", c, bus_if.dq_out, exp_d);
            end
        end
        bus_if.wr_go   = 1'b0;
        bus_if.q_valid = 1'b0;
    endtask

    task automatic test_mid_reset();
        logic [5:0]        obs;
        logic [5:0]        exp_f;
        logic [BEAT_W-1:0] exp_d;
        bus_if.q_valid = 1'b1;
        bus_if.wr_lat  = '0;
        for (int c = 0; c <= 21; c++) begin
            @(posedge clk); #1;
            bus_if.q_data = (c <= 2) ? mk(8'h50) : mk(8'h60);
            bus_if.wr_go  = (c == 2) || (c == 10);
            rst           = !((c == 6) || (c == 7));
            @(negedge clk);
            if (c >= 3 && c <= 5) begin
                exp_f = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
                exp_d = BEAT_W'(8'h50 + (c - 3));
            end else if (c >= 11 && c <= 18) begin
                exp_f = {1'b0, 1'b1, c == 18, 1'b1, 1'b0, 1'b0};
                exp_d = BEAT_W'(8'h60 + (c - 11));
            end else begin
                exp_f = {(c == 2) || (c == 10), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
                exp_d = '0;
            end
            obs = {bus_if.q_pop, bus_if.dq_valid, bus_if.dq_last, bus_if.busy,
                   bus_if.err_underrun, bus_if.err_busy};
            checks++;
            if (obs !== exp_f) begin
                errors++;
                $display("FAIL midrst_flags cyc %0d got %b exp %b", c, obs, exp_f);
            end
            checks++;
            if (bus_if.dq_out !== exp_d) begin
                errors++;
                $display("FAIL midrst_dq_out cyc %0d got %h exp %h", c, bus_if.dq_out, exp_d);
            end
        end
        bus_if.wr_go   = 1'b0;
        bus_if.q_valid = 1'b0;
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b0;
        bus_if.q_valid = 1'b0;
        bus_if.q_data  = '0;
        bus_if.wr_go   = 1'b0;
        bus_if.wr_lat  = '0;

        test_reset();
        test_single_lat3();
        test_back_to_back();
        test_underrun();
        test_busy_collision();
        test_mid_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
